// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Two-requester single-port memory arbiter with bounded bursts.
//           Commands go out through registers; read data is routed back by tag.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          rr;
  logic          rr_nxt;

  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Read-return pipeline: stage 1 lines up with mem_rd_en, stage 2 with mem_rdata.
  logic          rd_v1;
  logic          rd_id1;
  logic          rd_v2;
  logic          rd_id2;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || !rr)) begin
            gnt0      = 1'b1;
            state_nxt = OWN0;
            cnt_nxt   = 4'd1;
          end else if (req1) begin
            gnt1      = 1'b1;
            state_nxt = OWN1;
            cnt_nxt   = 4'd1;
          end
        end
        OWN0: begin
          if (req0 && ((cnt < BURST_MAX) || !req1)) begin
            gnt0 = 1'b1;
            if (cnt < BURST_MAX) cnt_nxt = cnt + 4'd1;
          end else if (req1) begin
            gnt1      = 1'b1;
            state_nxt = OWN1;
            cnt_nxt   = 4'd1;
            rr_nxt    = 1'b1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            rr_nxt    = 1'b1;
          end
        end
        OWN1: begin
          if (req1 && ((cnt < BURST_MAX) || !req0)) begin
            gnt1 = 1'b1;
            if (cnt < BURST_MAX) cnt_nxt = cnt + 4'd1;
          end else if (req0) begin
            gnt0      = 1'b1;
            state_nxt = OWN0;
            cnt_nxt   = 4'd1;
            rr_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            rr_nxt    = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign accept    = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rr        <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_v1     <= 1'b0;
      rd_id1    <= 1'b0;
      rd_v2     <= 1'b0;
      rd_id2    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr        <= rr_nxt;
      mem_wr_en <= accept & sel_we;
      mem_rd_en <= accept & ~sel_we;
      if (accept) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      rd_v1     <= accept & ~sel_we;
      rd_id1    <= gnt1;
      rd_v2     <= rd_v1;
      rd_id2    <= rd_id1;
    end
  end

  assign rvalid0 = rd_v2 & ~rd_id2;
  assign rvalid1 = rd_v2 & rd_id2;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  a_gnt_exclusive: assert property (@(posedge clk) !(gnt0 && gnt1));
  a_gnt_needs_req: assert property (@(posedge clk) (!gnt0 || req0) && (!gnt1 || req1));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed vector table plus hand-built corner sequences for mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en, mem_rd_en;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];

  mem_arbiter #(.AW(8), .DW(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, preloaded with the interleave pattern.
  always @(posedge clk) begin
    if (!reset) begin
      mem[1]    <= 8'h11;
      mem[2]    <= 8'h22;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       rst, r0, r1, w0, w1;
    logic [7:0] a0, a1, d0, d1;
    logic       g0, g1, wr, rd, v0, v1;
    logic [7:0] ea, ed, er;
  } vec_t;

  function automatic vec_t mk(input int rs, r0, r1, w0, w1, a0, a1, d0, d1,
                              input int g0, g1, wr, rd, v0, v1, ea, ed, er);
    vec_t v;
    v.rst = 1'(rs); v.r0 = 1'(r0); v.r1 = 1'(r1); v.w0 = 1'(w0); v.w1 = 1'(w1);
    v.a0 = 8'(a0); v.a1 = 8'(a1); v.d0 = 8'(d0); v.d1 = 8'(d1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.wr = 1'(wr); v.rd = 1'(rd);
    v.v0 = 1'(v0); v.v1 = 1'(v1);
    v.ea = 8'(ea); v.ed = 8'(ed); v.er = 8'(er);
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
  task automatic drive(input int rs, r0, r1, w0, w1, a0, a1, d0, d1);
    @(posedge clk);
    #1;
    reset = 1'(rs); req0 = 1'(r0); req1 = 1'(r1); we0 = 1'(w0); we1 = 1'(w1);
    addr0 = 8'(a0); addr1 = 8'(a1); wdata0 = 8'(d0); wdata1 = 8'(d1);
    #2;
  endtask

  task automatic check_row(input vec_t v, input int i);
    chk1($sformatf("row%0d gnt0", i), gnt0, v.g0);
    chk1($sformatf("row%0d gnt1", i), gnt1, v.g1);
    chk1($sformatf("row%0d mem_wr_en", i), mem_wr_en, v.wr);
    chk1($sformatf("row%0d mem_rd_en", i), mem_rd_en, v.rd);
    chk1($sformatf("row%0d rvalid0", i), rvalid0, v.v0);
    chk1($sformatf("row%0d rvalid1", i), rvalid1, v.v1);
    if (v.wr || v.rd) chk8($sformatf("row%0d mem_addr", i), mem_addr, v.ea);
    if (v.wr)         chk8($sformatf("row%0d mem_wdata", i), mem_wdata, v.ed);
    if (v.v0)         chk8($sformatf("row%0d rdata0", i), rdata0, v.er);
    if (v.v1)         chk8($sformatf("row%0d rdata1", i), rdata1, v.er);
  endtask

  vec_t tbl [21];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic got;

    //              rs r0 r1 w0 w1  a0    a1    d0    d1   g0 g1 wr rd v0 v1  ea    ed    er
    tbl[0]  = mk(0, 1, 0, 1, 0, 'h10, 'h00, 'hA5, 'h00,  0, 0, 0, 0, 0, 0, 'h00, 'h00, 'h00);
    tbl[1]  = mk(1, 1, 0, 1, 0, 'h10, 'h00, 'hA5, 'h00,  1, 0, 0, 0, 0, 0, 'h00, 'h00, 'h00);
    tbl[2]  = mk(1, 1, 0, 0, 0, 'h10, 'h00, 'h00, 'h00,  1, 0, 1, 0, 0, 0, 'h10, 'hA5, 'h00);
    tbl[3]  = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 0, 1, 0, 0, 'h10, 'h00, 'h00);
    tbl[4]  = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 0, 0, 1, 0, 'h00, 'h00, 'hA5);
    tbl[5]  = mk(1, 1, 1, 0, 0, 'h01, 'h02, 'h00, 'h00,  0, 1, 0, 0, 0, 0, 'h00, 'h00, 'h00);
    tbl[6]  = mk(1, 1, 0, 0, 0, 'h01, 'h02, 'h00, 'h00,  1, 0, 0, 1, 0, 0, 'h02, 'h00, 'h00);
    tbl[7]  = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 0, 1, 0, 1, 'h01, 'h00, 'h22);
    tbl[8]  = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 0, 0, 1, 0, 'h00, 'h00, 'h11);
    tbl[9]  = mk(1, 0, 1, 0, 1, 'h00, 'h30, 'h00, 'h5A,  0, 1, 0, 0, 0, 0, 'h00, 'h00, 'h00);
    tbl[10] = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 1, 0, 0, 0, 'h30, 'h5A, 'h00);
    tbl[11] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  1, 0, 0, 0, 0, 0, 'h00, 'h00, 'h00);
    tbl[12] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  1, 0, 1, 0, 0, 0, 'h40, 'h01, 'h00);
    tbl[13] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  1, 0, 1, 0, 0, 0, 'h40, 'h01, 'h00);
    tbl[14] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  1, 0, 1, 0, 0, 0, 'h40, 'h01, 'h00);
    tbl[15] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  0, 1, 1, 0, 0, 0, 'h40, 'h01, 'h00);
    tbl[16] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  0, 1, 1, 0, 0, 0, 'h50, 'h02, 'h00);
    tbl[17] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  0, 1, 1, 0, 0, 0, 'h50, 'h02, 'h00);
    tbl[18] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  0, 1, 1, 0, 0, 0, 'h50, 'h02, 'h00);
    tbl[19] = mk(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02,  1, 0, 1, 0, 0, 0, 'h50, 'h02, 'h00);
    tbl[20] = mk(1, 0, 0, 0, 0, 'h00, 'h00, 'h00, 'h00,  0, 0, 1, 0, 0, 0, 'h40, 'h01, 'h00);

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1,
            tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      check_row(tbl[i], i);
    end

    // Both requesters held from reset: four grants each, starting with 0.
    drive(0, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02);
    chk1("burst reset gnt0", gnt0, 1'b0);
    chk1("burst reset gnt1", gnt1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 1, 1, 1, 'h40, 'h50, 'h01, 'h02);
      chk1($sformatf("burst%0d gnt0", i), gnt0, (i < 4) || (i == 8));
      chk1($sformatf("burst%0d gnt1", i), gnt1, (i >= 4) && (i < 8));
    end

    // Lone requester 1 never stalls; requester 0 then wins within two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 0, 'h01, 'h02, 0, 0);
      chk1($sformatf("lone%0d gnt1", i), gnt1, 1'b1);
      chk1($sformatf("lone%0d gnt0", i), gnt0, 1'b0);
    end
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 0, 0, 'h01, 'h02, 0, 0);
      if (gnt0) got = 1'b1;
    end
    chk1("lone preempt gnt0", got, 1'b1);

    // Reset one cycle after a read is accepted kills the return.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 'h01, 'h02, 0, 0);
    chk1("rstmid accept gnt0", gnt0, 1'b1);
    drive(0, 1, 1, 0, 0, 'h01, 'h02, 0, 0);
    chk1("rstmid rd_en", mem_rd_en, 1'b1);
    chk1("rstmid held gnt0", gnt0, 1'b0);
    chk1("rstmid held gnt1", gnt1, 1'b0);
    drive(1, 1, 1, 0, 0, 'h01, 'h02, 0, 0);
    chk1("rstmid rvalid0", rvalid0, 1'b0);
    chk1("rstmid rvalid1", rvalid1, 1'b0);
    chk1("rstmid rd_en after", mem_rd_en, 1'b0);
    chk1("rstmid wr_en after", mem_wr_en, 1'b0);
    chk1("rstmid regrant gnt0", gnt0, 1'b1);
    chk1("rstmid regrant gnt1", gnt1, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("rstmid rd2 en", mem_rd_en, 1'b1);
    chk8("rstmid rd2 addr", mem_addr, 8'h01);
    chk1("rstmid rd2 early rvalid0", rvalid0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("rstmid rd2 rvalid0", rvalid0, 1'b1);
    chk1("rstmid rd2 rvalid1", rvalid1, 1'b0);
    chk8("rstmid rd2 rdata0", rdata0, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
